// File: rtl/mux_scan_sampler.sv
// Sequential scanner for a 4:1 mux: steps sel through channels 0..3, samples mux_in after a
// programmable settle time, and hands the packed 4-bit frame downstream over valid/ready.
module mux_scan_sampler #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mux_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       changed
);

    localparam int unsigned CntW = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StScan, StOut} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [3:0]      frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            changed_q, changed_d;
    logic [3:0]      last_acc_q, last_acc_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        busy_d        = busy_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        changed_d     = changed_q;
        last_acc_d    = last_acc_q;

        unique case (state_q)
            StIdle: begin
                sel_d  = 2'd0;
                busy_d = 1'b0;
                if (en) begin
                    state_d = StScan;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StScan: begin
                if (!en) begin
                    // Abort wins over a sample landing on the same edge.
                    state_d  = StIdle;
                    sel_d    = 2'd0;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    shadow_d = '0;
                end else if (cnt_q == CntLast) begin
                    cnt_d            = '0;
                    shadow_d[sel_q]  = mux_in;
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        frame_d       = shadow_d;
                        changed_d     = (shadow_d != last_acc_q);
                        frame_valid_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = StOut;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                if (frame_ready) begin
                    last_acc_d    = frame_q;
                    frame_valid_d = 1'b0;
                    sel_d         = 2'd0;
                    cnt_d         = '0;
                    if (en) begin
                        state_d = StScan;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            sel_q         <= 2'd0;
            busy_q        <= 1'b0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            last_acc_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            busy_q        <= busy_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            last_acc_q    <= last_acc_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Scoreboard bench for mux_scan_sampler: one instance with SETTLE=1, one with SETTLE=3.
module tb_mux_scan_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1_n, en1, rdy1, fv1, busy1, chg1;
    logic [1:0] sel1;
    logic [3:0] frame1, a1;
    logic       rst3_n, en3, rdy3, fv3, busy3, chg3;
    logic [1:0] sel3;
    logic [3:0] frame3, a3;
    logic       mux1, mux3;

    // Behavioural 4:1 mux in front of each scanner.
    assign mux1 = a1[sel1];
    assign mux3 = a3[sel3];

    mux_scan_sampler #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .mux_in(mux1), .sel(sel1), .busy(busy1),
        .frame(frame1), .frame_valid(fv1), .frame_ready(rdy1), .changed(chg1)
    );

    mux_scan_sampler #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst3_n), .en(en3), .mux_in(mux3), .sel(sel3), .busy(busy3),
        .frame(frame3), .frame_valid(fv3), .frame_ready(rdy3), .changed(chg3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] q1[$];  // {changed, frame}
    logic [4:0] q3[$];
    logic [4:0] exp;
    logic [3:0] last1 = 4'd0;
    logic [3:0] last3 = 4'd0;
    bit ok;

    task automatic wait_fv1(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fv1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fv3(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fv3) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({sel1, busy1, frame1, fv1, chg1} !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got sel=%0d busy=%0b frame=%b fv=%0b chg=%0b, want all 0",
                         sel1, busy1, frame1, fv1, chg1);
            end
            a1 = ~a1;
        end
        rst1_n = 1'b1;
        a1     = 4'b1010;
        q1.push_back({(a1 != last1), a1});
        @(negedge clk);
        n_tests++;
        if (busy1 !== 1'b1 || sel1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%0b sel=%0d, want busy=1 sel=0", busy1, sel1);
        end
    endtask

    task automatic test_basic;
        for (int ch = 1; ch < 4; ch++) begin
            @(negedge clk);
            n_tests++;
            if (sel1 !== 2'(ch) || busy1 !== 1'b1 || fv1 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_sel: got sel=%0d busy=%0b fv=%0b, want sel=%0d busy=1 fv=0",
                         sel1, busy1, fv1, ch);
            end
        end
        @(negedge clk);
        n_tests++;
        if (fv1 !== 1'b1 || busy1 !== 1'b0 || sel1 !== 2'd3 || q1.size() == 0) begin
            n_fail++;
            $display("FAIL basic_valid: got fv=%0b busy=%0b sel=%0d, want fv=1 busy=0 sel=3",
                     fv1, busy1, sel1);
        end else begin
            exp = q1.pop_front();
            n_tests++;
            if ({chg1, frame1} !== exp) begin
                n_fail++;
                $display("FAIL basic_frame: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame1, chg1, exp[3:0], exp[4]);
            end
            last1 = exp[3:0];
        end
        q1.push_back({(a1 != last1), a1});
        @(negedge clk);
        n_tests++;
        if (fv1 !== 1'b0 || busy1 !== 1'b1 || sel1 !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_restart: got fv=%0b busy=%0b sel=%0d, want fv=0 busy=1 sel=0",
                     fv1, busy1, sel1);
        end
    endtask

    task automatic test_backpressure;
        rdy1 = 1'b0;
        wait_fv1(ok);
        n_tests++;
        if (!ok || q1.size() == 0) begin
            n_fail++;
            $display("FAIL bp_timeout: frame_valid never rose");
        end else begin
            exp = q1.pop_front();
            n_tests++;
            if ({chg1, frame1} !== exp) begin
                n_fail++;
                $display("FAIL bp_frame: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame1, chg1, exp[3:0], exp[4]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (fv1 !== 1'b1 || frame1 !== 4'b1010 || sel1 !== 2'd3 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got fv=%0b frame=%b sel=%0d busy=%0b, want 1 1010 3 0",
                         fv1, frame1, sel1, busy1);
            end
        end
        rdy1 = 1'b1;
        @(negedge clk);
        last1 = 4'b1010;
        n_tests++;
        if (fv1 !== 1'b0 || busy1 !== 1'b1 || sel1 !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_transfer: got fv=%0b busy=%0b sel=%0d, want fv=0 busy=1 sel=0",
                     fv1, busy1, sel1);
        end
    endtask

    task automatic test_change_detect;
        a1 = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            q1.push_back({(a1 != last1), a1});
            wait_fv1(ok);
            n_tests++;
            if (!ok || q1.size() == 0) begin
                n_fail++;
                $display("FAIL chg_timeout: frame_valid never rose (frame %0d)", k);
            end else begin
                exp = q1.pop_front();
                n_tests++;
                if ({chg1, frame1} !== exp) begin
                    n_fail++;
                    $display("FAIL chg_frame%0d: got frame=%b chg=%0b, want frame=%b chg=%0b",
                             k, frame1, chg1, exp[3:0], exp[4]);
                end
                last1 = exp[3:0];
            end
        end
    endtask

    task automatic test_abort;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy1 && sel1 == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_reach: sel never reached 2 while busy");
        end
        en1 = 1'b0;
        a1  = 4'b0011;
        @(negedge clk);
        n_tests++;
        if (busy1 !== 1'b0 || sel1 !== 2'd0 || fv1 !== 1'b0 || frame1 !== 4'b0101) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%0b sel=%0d fv=%0b frame=%b, want 0 0 0 0101",
                     busy1, sel1, fv1, frame1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (fv1 !== 1'b0 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle: got fv=%0b busy=%0b, want 0 0", fv1, busy1);
            end
        end
        en1 = 1'b1;
        q1.push_back({(a1 != last1), a1});
        wait_fv1(ok);
        n_tests++;
        if (!ok || q1.size() == 0) begin
            n_fail++;
            $display("FAIL abort_timeout: frame_valid never rose after re-enable");
        end else begin
            exp = q1.pop_front();
            n_tests++;
            if ({chg1, frame1} !== exp) begin
                n_fail++;
                $display("FAIL abort_frame: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame1, chg1, exp[3:0], exp[4]);
            end
            last1 = exp[3:0];
        end
    endtask

    task automatic test_settle3;
        int cyc;
        rst3_n = 1'b1;
        q3.push_back({(a3 != last3), a3});
        for (int ch = 0; ch < 4; ch++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                n_tests++;
                if (sel3 !== 2'(ch) || busy3 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL s3_sel: got sel=%0d busy=%0b, want sel=%0d busy=1 (cycle %0d)",
                             sel3, busy3, ch, k);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (fv3 !== 1'b1 || q3.size() == 0) begin
            n_fail++;
            $display("FAIL s3_valid: got fv=%0b, want 1", fv3);
        end else begin
            exp = q3.pop_front();
            n_tests++;
            if ({chg3, frame3} !== exp) begin
                n_fail++;
                $display("FAIL s3_frame0: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame3, chg3, exp[3:0], exp[4]);
            end
            last3 = exp[3:0];
        end
        q3.push_back({(a3 != last3), a3});
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (fv3) break;
        end
        n_tests++;
        if (cyc != 13 || fv3 !== 1'b1) begin
            n_fail++;
            $display("FAIL s3_period: got %0d cycles fv=%0b, want 13 cycles fv=1", cyc, fv3);
        end else begin
            exp = q3.pop_front();
            n_tests++;
            if ({chg3, frame3} !== exp) begin
                n_fail++;
                $display("FAIL s3_frame1: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame3, chg3, exp[3:0], exp[4]);
            end
        end
        rst3_n = 1'b0;
        a3     = 4'b0000;
        @(negedge clk);
        last3 = 4'd0;
        n_tests++;
        if ({sel3, busy3, frame3, fv3, chg3} !== 9'd0) begin
            n_fail++;
            $display("FAIL s3_reset_out: got sel=%0d busy=%0b frame=%b fv=%0b chg=%0b, want all 0",
                     sel3, busy3, frame3, fv3, chg3);
        end
        rst3_n = 1'b1;
        q3.push_back({(a3 != last3), a3});
        wait_fv3(ok);
        n_tests++;
        if (!ok || q3.size() == 0) begin
            n_fail++;
            $display("FAIL s3_timeout: frame_valid never rose after reset");
        end else begin
            exp = q3.pop_front();
            n_tests++;
            if ({chg3, frame3} !== exp) begin
                n_fail++;
                $display("FAIL s3_frame2: got frame=%b chg=%0b, want frame=%b chg=%0b",
                         frame3, chg3, exp[3:0], exp[4]);
            end
        end
    endtask

    initial begin
        rst1_n = 1'b0;
        en1    = 1'b1;
        rdy1   = 1'b1;
        a1     = 4'b0110;
        rst3_n = 1'b0;
        en3    = 1'b1;
        rdy3   = 1'b1;
        a3     = 4'b1100;
        test_reset();
        test_basic();
        test_backpressure();
        test_change_detect();
        test_abort();
        test_settle3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
# mux_scan_sampler

Sequential channel scanner sitting around the 4:1 mux. It drives the mux select `sel[1:0]` through channels 0..3, waits a programmable settle time on each, and samples the mux output `mux_in`. It packs the four samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake, flagging whether the frame differs from the last one accepted.

## Interface
- `SETTLE`, default 1: cycles `sel` is held stable per channel before sampling; legal range 1..16; counter width `$clog2(SETTLE+1)`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `en`  in  1  scan enable; level-sensitive.
- `mux_in`  in  1  output of the 4:1 mux (the mux's `f`).
- `sel`  out  2  mux select (drives the mux's `s`); registered.
- `busy`  out  1  high while a scan is in progress (SCAN state).
- `frame`  out  4  `frame[i]` = sample taken with `sel==i`; registered.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  downstream accepts frame.
- `changed`  out  1  `frame != last_accepted`; meaningful only while `frame_valid`.

## Operation
- States: IDLE, SCAN, OUT. Internal registers: `cnt`, `shadow[3:0]` (partial frame), `last_accepted[3:0]`.
- IDLE: `sel`=0, `busy`=0, `frame_valid`=0.
  - If `en`=1: go to SCAN, `sel`=0, `cnt`=0.
- SCAN: `busy`=1; `cnt` increments each cycle.
  - On the edge where `cnt==SETTLE-1`: `shadow[sel] <= mux_in` and `cnt <= 0`.
    - If `sel<3`: `sel <= sel+1`.
    - If `sel==3`: `frame <= {mux_in, shadow[2:0]}`, `changed <= ({mux_in, shadow[2:0]} != last_accepted)`, `frame_valid <= 1`, go to OUT. `sel` holds 3.
  - If `en`=0 on any SCAN edge: abort. Go to IDLE, `sel`=0, `cnt`=0, `shadow` discarded, no frame produced. Abort takes priority over sampling in the same cycle.
- OUT: `frame`, `changed` and `sel` are held stable; `en` is ignored.
  - Transfer occurs on an edge with `frame_valid && frame_ready`. On transfer: `last_accepted <= frame`, `frame_valid <= 0`.
    - If `en`=1: go to SCAN with `sel`=0, `cnt`=0.
    - Otherwise go to IDLE.
  - `frame_ready` asserted while not valid has no effect.
- `frame` retains its last value after transfer. It is only updated on the next completed scan.
- Only one frame is ever buffered. There is no overrun, because scanning stops in OUT.

## Timing
- Reset (`rst_n`=0 at an edge), regardless of state, including mid-scan and mid-OUT:
  - `sel`=0, `busy`=0, `frame`=0, `frame_valid`=0, `changed`=0.
  - `cnt`=0, `shadow`=0, `last_accepted`=0, state IDLE.
  - Any pending frame is dropped.
- `sel` changes only on edges. Channel `i` is driven for exactly `SETTLE` cycles, and `mux_in` is sampled at the last edge of that window. `mux_in` is assumed combinationally valid within one cycle.
- Latency: `en` sampled high at edge E0 puts SCAN in effect with `sel`=0 after E0. The samples are taken at E0+SETTLE, E0+2·SETTLE, E0+3·SETTLE and E0+4·SETTLE. `frame_valid` rises after edge E0+4·SETTLE.
- With `frame_ready` tied high and `en` high: one OUT cycle per frame, so one frame every `4·SETTLE+1` cycles. `frame_valid` is high for exactly 1 cycle per frame.
- `busy` and `frame_valid` are never high together.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 and `mux_in` toggling → `sel`=0, `busy`=0, `frame`=0, `frame_valid`=0, `changed`=0 throughout. First frame starts on the first edge after release.
- Basic scan, SETTLE=1: behavioural 4:1 mux model with `a`=4'b1010, `frame_ready`=1, `en` raised → `sel` sequence 0,1,2,3 for one cycle each, then `frame_valid` high for 1 cycle with `frame`=4'b1010, `changed`=1. Next scan restarts at `sel`=0.
- Backpressure: `frame_ready`=0 for 6 cycles after valid → `frame_valid` held high, `frame`=4'b1010 stable, `sel`=3. Raise `frame_ready` → single transfer, then `sel`=0 and `busy`=1 on the next cycle.
- Change detect: repeat `a`=4'b1010 → `changed`=0. Switch to `a`=4'b0101 → `changed`=1 and `frame`=4'b0101. Next identical frame → `changed`=0.
- Abort: drop `en` while `sel`=2 → `busy`=0, `sel`=0, no `frame_valid`, `frame` unchanged. Re-enable → full 4-channel scan with fresh samples.
- SETTLE=3: each `sel` value held exactly 3 cycles, frames every 13 cycles with `frame_ready`=1. Assert reset during OUT → `frame_valid`=0 after that edge and `last_accepted` is cleared, so the next frame of 4'b0000 reports `changed`=0.
